demux_8_buf: RTL and testbench
==============================

Name: demux_8_buf

Overview:
- Eight-output 32-bit demultiplexer with per-lane one-entry holding buffers, driven by a 3-bit select.
- Converse of the 8-input select mux: one producer word is steered into one of eight consumer lanes.
- Each lane presents its word on a valid/ack handshake and holds it until consumed.
- Used wherever a single result bus fans out to eight independent consumers, such as writeback distribution or per-unit operand delivery.

Parameters:
WIDTH, 32, data width of the input and of each lane
LANES, 8, number of output lanes; fixed at 8 to match the 3-bit select

Ports:
clock  input  1  rising-edge clock
reset  input  1  asynchronous, active-high reset
in_valid  input  1  producer presents in_data for lane select
in_ready  output  1  selected lane can accept this cycle
select  input  3  destination lane index
in_data  input  WIDTH  producer word
out0..out7  output  WIDTH each  lane data registers
out_valid  output  8  bit i set = lane i holds an unconsumed word
out_ack  input  8  bit i = consumer i takes lane i's word this cycle
occupied  output  4  count of set out_valid bits, range 0..8

Behaviour:
- Reset (async assert, applied immediately):
  - out0..out7 = 0, out_valid = 0, occupied = 0.
  - in_ready = 0 while reset is high.
- Lane i is "free" when out_valid[i] = 0, or when out_valid[i] = 1 and out_ack[i] = 1 in the same cycle (pass-through refill).
- in_ready:
  - Combinational: in_ready = free(select) and not reset.
  - Depends on select and out_ack[select] only, never on in_valid.
- Accept: in_valid and in_ready at a rising edge.
  - out[select] <= in_data, out_valid[select] <= 1.
  - Latency: one cycle; the word is visible on the lane the cycle after acceptance.
- Consume: out_ack[i] and out_valid[i] at an edge.
  - out_valid[i] <= 0, unless lane i is written on the same edge, in which case it stays 1 with the new data.
- Data retention:
  - out_ack[i] with out_valid[i] = 0 is ignored.
  - Lane data registers are not cleared on consume; a lane holds its last value until overwritten or reset.
- Blocked input: in_valid while in_ready = 0 accepts nothing and changes no state. The producer must hold in_valid, select and in_data stable until accepted.
- Per-edge scope:
  - Writes touch only the selected lane.
  - Acks to other lanes are processed independently on the same edge; any combination of the 8 ack bits may be set at once.
- occupied:
  - Registered; equals the popcount of out_valid.
  - Next value = current count + (accept and the lane was not a pass-through refill) − (number of valid lanes acked and not refilled).
  - Never exceeds 8 and never underflows.
- Full condition: occupied = 8 with no acks gives in_ready = 0 for every select value.
- Reset mid-transfer: all pending words are discarded, and an accept on the same edge as reset assertion is lost.
- X-safety: select is evaluated only when in_valid = 1, and out_ack bits for empty lanes are don't-care.

Test Plan:
- Reset then idle:
  - Assert reset with in_valid = 1.
  - Required: in_ready = 0, all outN = 0, out_valid = 0x00, occupied = 0.
- Single write:
  - select = 5, in_data = 0xDEADBEEF, in_valid for 1 cycle.
  - Next cycle: out5 = 0xDEADBEEF, out_valid = 0x20, occupied = 1, all other lanes 0.
- Backpressure:
  - Lane 2 holds 0x11111111 with no ack; drive select = 2, in_data = 0x22222222, in_valid = 1 for 3 cycles.
  - Required: in_ready = 0 throughout, out2 stays 0x11111111.
  - Then pulse out_ack[2]: in_ready = 1 that cycle and out2 = 0x22222222 next cycle, with out_valid[2] remaining 1.
- Fill all lanes:
  - Write lanes 0..7 with values 0x100+i, no acks.
  - Required: occupied = 8, out_valid = 0xFF, in_ready = 0 for all 8 select values.
  - Then out_ack = 0xFF: out_valid = 0x00, occupied = 0, and the data registers keep 0x100+i.
- Simultaneous write and acks:
  - Lanes 1 and 3 valid; in one cycle write lane 6 (0xCAFE0006) and ack lanes 1 and 3.
  - Required: out_valid = 0x40, occupied = 1.
  - An ack to empty lane 0 in that cycle changes nothing.
- Reset mid-operation:
  - Lanes 0 and 4 valid and an accept in progress; assert reset asynchronously mid-cycle.
  - Required: out_valid and outputs go to 0 immediately, with no write on the following edge.

Source files
------------

// File: rtl/demux_8_buf.sv
// demux_8_buf: steers one producer word into one of eight lanes.
// Each lane is a one-entry holding buffer with a valid/ack handshake.
// A lane being acked in the same cycle counts as free, so a full lane
// can be refilled without a bubble.
module demux_8_buf #(
  parameter int WIDTH = 32,
  parameter int LANES = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       select,
  input  logic [WIDTH-1:0] in_data,
  output logic [WIDTH-1:0] out0,
  output logic [WIDTH-1:0] out1,
  output logic [WIDTH-1:0] out2,
  output logic [WIDTH-1:0] out3,
  output logic [WIDTH-1:0] out4,
  output logic [WIDTH-1:0] out5,
  output logic [WIDTH-1:0] out6,
  output logic [WIDTH-1:0] out7,
  output logic [LANES-1:0] out_valid,
  input  logic [LANES-1:0] out_ack,
  output logic [3:0]       occupied
);

  // Count of set bits in a lane-valid vector (0..8).
  function automatic logic [3:0] popcount(input logic [LANES-1:0] v);
    logic [3:0] cnt;
    cnt = 4'd0;
    for (int i = 0; i < LANES; i++) begin
      cnt = cnt + {3'b000, v[i]};
    end
    return cnt;
  endfunction

  logic [LANES-1:0] valid_q;
  logic [LANES-1:0] valid_d;
  logic [3:0]       occupied_q;
  logic [3:0]       occupied_d;
  logic [WIDTH-1:0] data_q [LANES];
  logic [WIDTH-1:0] data_d [LANES];

  logic [LANES-1:0] lane_free_s;
  logic [LANES-1:0] wr_vec_s;
  logic [LANES-1:0] clr_vec_s;
  logic             accept_s;

  // Handshake: a lane is free when empty or being consumed this cycle.
  // in_ready deliberately ignores in_valid.
  always_comb begin
    lane_free_s = ~valid_q | out_ack;
    if (reset) begin
      in_ready = 1'b0;
    end else begin
      in_ready = lane_free_s[select];
    end
    accept_s = in_valid & in_ready;
  end

  // Per-lane write and consume vectors. Acks to empty lanes are masked off.
  always_comb begin
    wr_vec_s = {LANES{1'b0}};
    if (accept_s) begin
      wr_vec_s[select] = 1'b1;
    end else begin
      wr_vec_s = {LANES{1'b0}};
    end
    clr_vec_s = out_ack & valid_q;
  end

  // Next-state: a write on the same edge as a consume keeps the lane valid.
  always_comb begin
    valid_d    = (valid_q & ~clr_vec_s) | wr_vec_s;
    occupied_d = popcount(valid_d);
    for (int i = 0; i < LANES; i++) begin
      if (wr_vec_s[i]) begin
        data_d[i] = in_data;
      end else begin
        data_d[i] = data_q[i];
      end
    end
  end

  // State registers; reset discards every pending word and any same-edge accept.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      valid_q    <= {LANES{1'b0}};
      occupied_q <= 4'd0;
      for (int i = 0; i < LANES; i++) begin
        data_q[i] <= {WIDTH{1'b0}};
      end
    end else begin
      valid_q    <= valid_d;
      occupied_q <= occupied_d;
      for (int i = 0; i < LANES; i++) begin
        data_q[i] <= data_d[i];
      end
    end
  end

  assign out_valid = valid_q;
  assign occupied  = occupied_q;
  assign out0      = data_q[0];
  assign out1      = data_q[1];
  assign out2      = data_q[2];
  assign out3      = data_q[3];
  assign out4      = data_q[4];
  assign out5      = data_q[5];
  assign out6      = data_q[6];
  assign out7      = data_q[7];

endmodule

// File: tb/tb_demux_8_buf.sv
// Testbench for demux_8_buf: table of per-cycle vectors with a scoreboard
// of expected post-edge state, plus a hand-written reset-mid-transfer sequence.
module tb_demux_8_buf;

  logic        clock;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  select;
  logic [31:0] in_data;
  logic [31:0] out0, out1, out2, out3, out4, out5, out6, out7;
  logic [7:0]  out_valid;
  logic [7:0]  out_ack;
  logic [3:0]  occupied;

  int checks = 0;
  int errors = 0;

  demux_8_buf dut (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .select(select), .in_data(in_data),
    .out0(out0), .out1(out1), .out2(out2), .out3(out3),
    .out4(out4), .out5(out5), .out6(out6), .out7(out7),
    .out_valid(out_valid), .out_ack(out_ack), .occupied(occupied)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic        v;
    logic [2:0]  sel;
    logic [31:0] data;
    logic [7:0]  ack;
    logic        rdy;   // expected in_ready during the cycle
    logic [7:0]  ev;    // expected out_valid after the edge
    logic [3:0]  eo;    // expected occupied after the edge
  } vec_t;

  typedef struct {
    logic [7:0]       v;
    logic [3:0]       occ;
    logic [7:0][31:0] d;
  } exp_t;

  vec_t             tbl[$];
  exp_t             sb[$];
  logic [7:0][31:0] m_data;

  function automatic vec_t mk(logic v, logic [2:0] s, logic [31:0] d, logic [7:0] a,
                              logic r, logic [7:0] ev, logic [3:0] eo);
    vec_t t;
    t.v = v; t.sel = s; t.data = d; t.ack = a; t.rdy = r; t.ev = ev; t.eo = eo;
    return t;
  endfunction

  function automatic logic [31:0] lane(int i);
    case (i)
      0: return out0;
      1: return out1;
      2: return out2;
      3: return out3;
      4: return out4;
      5: return out5;
      6: return out6;
      7: return out7;
      default: return 32'hxxxx_xxxx;
    endcase
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one vector, check in_ready, push expectation, compare after the edge.
  task automatic apply(input vec_t t);
    exp_t e;
    @(negedge clock);
    in_valid = t.v; select = t.sel; in_data = t.data; out_ack = t.ack;
    #1;
    chk("in_ready", {31'd0, in_ready}, {31'd0, t.rdy});
    if (t.v && t.rdy) m_data[t.sel] = t.data;
    e.v = t.ev; e.occ = t.eo; e.d = m_data;
    sb.push_back(e);
    @(posedge clock);
    #1;
    if (sb.size() == 0) begin
      chk("scoreboard_empty", 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      chk("out_valid", {24'd0, out_valid}, {24'd0, e.v});
      chk("occupied", {28'd0, occupied}, {28'd0, e.occ});
      for (int i = 0; i < 8; i++) chk($sformatf("out%0d", i), lane(i), e.d[i]);
    end
  endtask

  logic [7:0] fill_v [8];

  initial begin
    fill_v = '{8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F, 8'h3F, 8'h7F, 8'hFF};
    m_data = '0;

    // Single write, then an idle cycle
    tbl.push_back(mk(1'b1, 3'd5, 32'hDEADBEEF, 8'h00, 1'b1, 8'h20, 4'd1));
    tbl.push_back(mk(1'b0, 3'd0, 32'h0,        8'h00, 1'b1, 8'h20, 4'd1));
    // Backpressure on lane 2, then pass-through refill
    tbl.push_back(mk(1'b1, 3'd2, 32'h11111111, 8'h00, 1'b1, 8'h24, 4'd2));
    for (int k = 0; k < 3; k++)
      tbl.push_back(mk(1'b1, 3'd2, 32'h22222222, 8'h00, 1'b0, 8'h24, 4'd2));
    tbl.push_back(mk(1'b1, 3'd2, 32'h22222222, 8'h04, 1'b1, 8'h24, 4'd2));
    tbl.push_back(mk(1'b0, 3'd0, 32'h0,        8'h24, 1'b1, 8'h00, 4'd0));
    // Fill all lanes
    for (int i = 0; i < 8; i++)
      tbl.push_back(mk(1'b1, 3'(i), 32'h100 + 32'(i), 8'h00, 1'b1, fill_v[i], 4'(i + 1)));
    // Full: every select blocked, writes ignored
    for (int i = 0; i < 8; i++)
      tbl.push_back(mk(1'b1, 3'(i), 32'hBAD0_0000, 8'h00, 1'b0, 8'hFF, 4'd8));
    // Drain all at once; data retained
    tbl.push_back(mk(1'b0, 3'd0, 32'h0, 8'hFF, 1'b1, 8'h00, 4'd0));
    // Simultaneous write and acks, including ack to empty lane 0
    tbl.push_back(mk(1'b1, 3'd1, 32'hA1, 8'h00, 1'b1, 8'h02, 4'd1));
    tbl.push_back(mk(1'b1, 3'd3, 32'hA3, 8'h00, 1'b1, 8'h0A, 4'd2));
    tbl.push_back(mk(1'b1, 3'd6, 32'hCAFE0006, 8'h0B, 1'b1, 8'h40, 4'd1));
    tbl.push_back(mk(1'b0, 3'd0, 32'h0, 8'h40, 1'b1, 8'h00, 4'd0));
    // Set up lanes 0 and 4 for the reset-mid-operation sequence
    tbl.push_back(mk(1'b1, 3'd0, 32'hA0, 8'h00, 1'b1, 8'h01, 4'd1));
    tbl.push_back(mk(1'b1, 3'd4, 32'hA4, 8'h00, 1'b1, 8'h11, 4'd2));

    // Reset with in_valid high
    reset = 1'b1; in_valid = 1'b1; select = 3'd3; in_data = 32'h12345678; out_ack = 8'h00;
    #7;
    chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
    chk("rst_out_valid", {24'd0, out_valid}, 32'd0);
    chk("rst_occupied", {28'd0, occupied}, 32'd0);
    for (int i = 0; i < 8; i++) chk($sformatf("rst_out%0d", i), lane(i), 32'd0);
    @(negedge clock);
    reset = 1'b0; in_valid = 1'b0;

    for (int n = 0; n < tbl.size(); n++) apply(tbl[n]);

    // Reset asserted mid-cycle while an accept to lane 2 is pending
    @(negedge clock);
    in_valid = 1'b1; select = 3'd2; in_data = 32'h55555555; out_ack = 8'h00;
    #1;
    chk("pre_rst_in_ready", {31'd0, in_ready}, 32'd1);
    #2;
    reset = 1'b1;
    #1;
    chk("mid_rst_out_valid", {24'd0, out_valid}, 32'd0);
    chk("mid_rst_occupied", {28'd0, occupied}, 32'd0);
    chk("mid_rst_out0", out0, 32'd0);
    chk("mid_rst_out4", out4, 32'd0);
    chk("mid_rst_in_ready", {31'd0, in_ready}, 32'd0);
    @(posedge clock);
    #1;
    chk("post_rst_out2", out2, 32'd0);
    chk("post_rst_out_valid", {24'd0, out_valid}, 32'd0);
    @(negedge clock);
    reset = 1'b0; in_valid = 1'b0;
    m_data = '0;
    apply(mk(1'b1, 3'd7, 32'h77777777, 8'h00, 1'b1, 8'h80, 4'd1));

    if (sb.size() != 0) chk("scoreboard_left", sb.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
